image_mem_arbiter: RTL and testbench
====================================

Name: image_mem_arbiter

Overview:
- Shares one single-port synchronous image memory (80x480 sprite/frame store) between two requesters.
- Display read path: boundary_select and the VGA pixel pipeline. Has absolute priority, fixed latency, never stalls.
- Write path: frame/sprite loader. Buffered in a small FIFO and drained only in cycles with no display request, i.e. blanking or idle.
- Sits between the image memory and the display/loader logic; clocked on clk_50.

Parameters:
- P_IMAGE_WIDTH, 80: image width in pixels.
- P_IMAGE_HEIGHT, 480: image height in pixels.
- P_ADDR_W, 16: memory address width; must satisfy 2^P_ADDR_W >= P_IMAGE_WIDTH*P_IMAGE_HEIGHT.
- P_DATA_W, 24: pixel width, packed {R[7:0],G[7:0],B[7:0]}.
- P_FIFO_DEPTH, 4: write FIFO entries; power of two, at least 2.

Ports:
- clk_50, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- disp_req, in, 1: display read request, sampled every cycle.
- disp_addr, in, P_ADDR_W: display read address.
- disp_valid, out, 1: read data valid, 1 cycle pulse.
- disp_data, out, P_DATA_W: read data.
- wr_valid, in, 1: loader write request.
- wr_addr, in, P_ADDR_W: write address.
- wr_data, in, P_DATA_W: write pixel.
- wr_ready, out, 1: FIFO can accept.
- mem_addr, out, P_ADDR_W: memory address.
- mem_we, out, 1: memory write enable.
- mem_wdata, out, P_DATA_W: memory write data.
- mem_rdata, in, P_DATA_W: memory read data, valid the cycle after the address edge.
- fifo_level, out, clog2(P_FIFO_DEPTH)+1: current FIFO occupancy.
- wr_drop, out, 1: sticky flag, an out-of-range write was dropped.
- grant, out, 2: current grant state, 00 IDLE, 01 DISP, 10 WRITE.

Behaviour:
- Reset values: all outputs 0. FIFO empty; read-return pipeline cleared; grant=IDLE. wr_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: FIFO contents and in-flight reads are discarded. No disp_valid pulse is emitted for requests sampled before reset.
- Grant FSM (registered, evaluated every edge):
  - DISP if disp_req=1.
  - else WRITE if fifo_level>0.
  - else IDLE.
  - No hysteresis; any state may follow any state.
- DISP cycle: mem_addr<=disp_addr, mem_we<=0. A matching pipeline tag enters the 3-stage return shift register.
- WRITE cycle: pop FIFO head; mem_addr<=head.addr, mem_wdata<=head.data, mem_we<=1, for exactly one cycle per entry.
- IDLE cycle: mem_we<=0; mem_addr and mem_wdata hold their previous values.
- Read latency: disp_req=1 sampled at edge T gives disp_valid=1 and disp_data=mem_rdata in the cycle after edge T+2 (3 cycles). Back-to-back requests give back-to-back valids.
- Display out-of-range read (disp_addr >= W*H): the memory is still read, but disp_data returned is 0 and disp_valid is still asserted. The range flag is carried through the pipeline.
- FIFO push rules:
  - Push on wr_valid & wr_ready.
  - wr_ready = (fifo_level < P_FIFO_DEPTH), from registered level only, with no combinational path from a same-cycle pop.
  - When full, wr_ready is 0 even if a pop occurs that cycle.
  - Simultaneous push and pop: level unchanged, order preserved.
- Out-of-range write (wr_addr >= W*H): handshake completes and the entry is not stored. wr_drop is set and held until reset.
- Writes are committed in acceptance order. Last write to an address wins.
- No read/write forwarding: a display read of an address still in the FIFO returns the old memory contents.
- Starvation: writes wait indefinitely while disp_req stays high. The loader must rely on blanking intervals.
- Range compare uses a constant W*H computed at elaboration, width P_ADDR_W+1.

Test Plan:
- Reset held 2 cycles during traffic -> all outputs 0; fifo_level=0; no disp_valid pulses afterward from pre-reset requests.
- disp_req=1, disp_addr=5 for one cycle, memory[5]=0xABCDEF -> disp_valid one cycle 3 cycles later with disp_data=0xABCDEF; mem_we never 1.
- With disp_req=0, push 4 writes (addr 0..3, data 0x10..0x13) back-to-back:
  - wr_ready falls only when level=4.
  - Each entry appears on mem_we/mem_addr in order, one per cycle.
  - fifo_level returns to 0.
- FIFO holding 3 entries, disp_req=1 for 10 cycles -> mem_we stays 0 and level stays 3; after disp_req drops, the 3 writes issue on consecutive cycles.
- Write to addr 38400 (=80*480) -> handshake completes, no mem_we, wr_drop=1 and held. Display read of addr 38400 -> disp_valid with disp_data=0.
- FIFO full with wr_valid=1 while a pop occurs -> no push that cycle; push occurs next cycle; level sequence 4,3,4.

Source files
------------

// File: rtl/image_mem_arbiter_if.sv
// Bundle of the display read port, the loader write port and the image memory port
// of the image memory arbiter. The arbiter connects through the slave modport.
interface image_mem_arbiter_if #(
    parameter int P_ADDR_W = 16,
    parameter int P_DATA_W = 24,
    parameter int P_LVL_W  = 3
);
    logic                disp_req;
    logic [P_ADDR_W-1:0] disp_addr;
    logic                disp_valid;
    logic [P_DATA_W-1:0] disp_data;

    logic                wr_valid;
    logic [P_ADDR_W-1:0] wr_addr;
    logic [P_DATA_W-1:0] wr_data;
    logic                wr_ready;

    logic [P_ADDR_W-1:0] mem_addr;
    logic                mem_we;
    logic [P_DATA_W-1:0] mem_wdata;
    logic [P_DATA_W-1:0] mem_rdata;

    logic [P_LVL_W-1:0]  fifo_level;
    logic                wr_drop;
    logic [1:0]          grant;

    modport slave (
        input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output disp_valid, disp_data, wr_ready, mem_addr, mem_we, mem_wdata,
        output fifo_level, wr_drop, grant
    );

    modport master (
        output disp_req, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  disp_valid, disp_data, wr_ready, mem_addr, mem_we, mem_wdata,
        input  fifo_level, wr_drop, grant
    );
endinterface

// File: rtl/image_mem_arbiter.sv
// Shares one single-port image memory between the display read path (absolute priority,
// fixed 3-cycle latency) and a FIFO-buffered loader write path drained in idle cycles.
module image_mem_arbiter #(
    parameter int P_IMAGE_WIDTH  = 80,
    parameter int P_IMAGE_HEIGHT = 480,
    parameter int P_ADDR_W       = 16,
    parameter int P_DATA_W       = 24,
    parameter int P_FIFO_DEPTH   = 4
) (
    input  logic               clk_50,
    input  logic               reset,
    image_mem_arbiter_if.slave bus
);
    localparam int LP_PTR_W = $clog2(P_FIFO_DEPTH);
    localparam int LP_LVL_W = LP_PTR_W + 1;
    localparam logic [P_ADDR_W:0]   LP_PIXELS  = (P_ADDR_W+1)'(P_IMAGE_WIDTH * P_IMAGE_HEIGHT);
    localparam logic [LP_LVL_W-1:0] LP_DEPTH   = LP_LVL_W'(P_FIFO_DEPTH);
    localparam logic [LP_LVL_W-1:0] LP_LVL_ONE = LP_LVL_W'(1);
    localparam logic [LP_PTR_W-1:0] LP_PTR_ONE = LP_PTR_W'(1);

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'b00,
        GNT_DISP  = 2'b01,
        GNT_WRITE = 2'b10
    } grant_e;

    grant_e              grant_q;
    logic [P_ADDR_W-1:0] mem_addr_q;
    logic                mem_we_q;
    logic [P_DATA_W-1:0] mem_wdata_q;

    logic [P_ADDR_W-1:0] fifo_addr_q [P_FIFO_DEPTH];
    logic [P_DATA_W-1:0] fifo_data_q [P_FIFO_DEPTH];
    logic [LP_PTR_W-1:0] wr_ptr_q;
    logic [LP_PTR_W-1:0] rd_ptr_q;
    logic [LP_LVL_W-1:0] level_q;
    logic [LP_LVL_W-1:0] level_d;
    logic                wr_ready_q;
    logic                wr_drop_q;

    // Return pipeline: bit 0 is the request just issued, bit 1 the one whose data is on mem_rdata.
    logic [1:0]          rd_valid_q;
    logic [1:0]          rd_oor_q;
    logic                disp_valid_q;
    logic [P_DATA_W-1:0] disp_data_q;

    logic wr_accept;
    logic wr_in_range;
    logic push;
    logic pop;
    logic disp_oor;

    always_comb begin
        wr_accept   = bus.wr_valid & wr_ready_q;
        wr_in_range = ({1'b0, bus.wr_addr} < LP_PIXELS);
        push        = wr_accept & wr_in_range;
        pop         = ~bus.disp_req & (level_q != '0);
        disp_oor    = ({1'b0, bus.disp_addr} >= LP_PIXELS);
        level_d     = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LP_LVL_ONE;
            2'b01:   level_d = level_q - LP_LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    generate
        for (genvar gi = 0; gi < P_FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk_50) begin
                if (push && (wr_ptr_q == LP_PTR_W'(gi))) begin
                    fifo_addr_q[gi] <= bus.wr_addr;
                    fifo_data_q[gi] <= bus.wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_50) begin
        if (reset) begin
            grant_q      <= GNT_IDLE;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            wr_ready_q   <= 1'b0;
            wr_drop_q    <= 1'b0;
            rd_valid_q   <= '0;
            rd_oor_q     <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            level_q    <= level_d;
            // Ready follows the registered level only, so a full FIFO refuses even on a pop cycle.
            wr_ready_q <= (level_d < LP_DEPTH);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + LP_PTR_ONE;
            end
            if (wr_accept && !wr_in_range) begin
                wr_drop_q <= 1'b1;
            end

            if (bus.disp_req) begin
                grant_q    <= GNT_DISP;
                mem_addr_q <= bus.disp_addr;
                mem_we_q   <= 1'b0;
            end else if (pop) begin
                grant_q     <= GNT_WRITE;
                mem_addr_q  <= fifo_addr_q[rd_ptr_q];
                mem_wdata_q <= fifo_data_q[rd_ptr_q];
                mem_we_q    <= 1'b1;
                rd_ptr_q    <= rd_ptr_q + LP_PTR_ONE;
            end else begin
                grant_q  <= GNT_IDLE;
                mem_we_q <= 1'b0;
            end

            rd_valid_q   <= {rd_valid_q[0], bus.disp_req};
            rd_oor_q     <= {rd_oor_q[0], disp_oor};
            disp_valid_q <= rd_valid_q[1];
            disp_data_q  <= (rd_valid_q[1] && !rd_oor_q[1]) ? bus.mem_rdata : '0;
        end
    end

    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.wr_ready   = wr_ready_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.fifo_level = level_q;
    assign bus.wr_drop    = wr_drop_q;
    assign bus.grant      = grant_q;
endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter: stimulus pushes expected reads/writes into queues,
// a negedge monitor pops and compares whenever disp_valid or mem_we is seen.
module tb_image_mem_arbiter;
    localparam int AW    = 16;
    localparam int DW    = 24;
    localparam int LW    = 3;

    logic clk_50 = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_50 = ~clk_50;

    image_mem_arbiter_if #(.P_ADDR_W(AW), .P_DATA_W(DW), .P_LVL_W(LW)) bus ();

    image_mem_arbiter #(
        .P_IMAGE_WIDTH (80),
        .P_IMAGE_HEIGHT(480),
        .P_ADDR_W      (AW),
        .P_DATA_W      (DW),
        .P_FIFO_DEPTH  (4)
    ) dut (
        .clk_50(clk_50),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous image memory: read data appears the cycle after the address edge.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk_50) begin
        if (reset) begin
            mem[5]     <= 24'hABCDEF;
            mem[38399] <= 24'h0F0F0F;
            mem[38400] <= 24'h123456;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd_exp = '0;
    bit          track  = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read or a memory write.
    always @(negedge clk_50) begin
        exp_t e;
        if (bus.disp_valid) begin
            if (rd_q.size() == 0) begin
                chk("disp_valid_unexpected", 32'(bus.disp_valid), 32'd0);
            end else begin
                e = rd_q.pop_front();
                chk("disp_data", 32'(bus.disp_data), e.d);
                chk("disp_latency", 32'(cyc), 32'(e.c));
                $display("read  data=0x%06h cycle=%0d", bus.disp_data, cyc);
            end
        end
        if (bus.mem_we) begin
            if (wr_q.size() == 0) begin
                chk("mem_we_unexpected", 32'(bus.mem_we), 32'd0);
            end else begin
                e = wr_q.pop_front();
                chk("mem_addr", 32'(bus.mem_addr), e.a);
                chk("mem_wdata", 32'(bus.mem_wdata), e.d);
                chk("mem_we_cycle", 32'(cyc), 32'(e.c));
                $display("write addr=%0d data=0x%06h cycle=%0d", bus.mem_addr, bus.mem_wdata, cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    // Read request sampled at the next edge T returns after edge T+2.
    task automatic step();
        if (bus.disp_req && track) rd_q.push_back('{a: 32'(bus.disp_addr), d: rd_exp, c: cyc + 3});
        tick();
    endtask

    task automatic push_wr(input int addr, input int data, input int due);
        wr_q.push_back('{a: 32'(addr), d: 32'(data), c: due});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_disp_valid"}, 32'(bus.disp_valid), 32'd0);
        chk({tag, "_disp_data"},  32'(bus.disp_data),  32'd0);
        chk({tag, "_wr_ready"},   32'(bus.wr_ready),   32'd0);
        chk({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
        chk({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
        chk({tag, "_mem_wdata"},  32'(bus.mem_wdata),  32'd0);
        chk({tag, "_fifo_level"}, 32'(bus.fifo_level), 32'd0);
        chk({tag, "_wr_drop"},    32'(bus.wr_drop),    32'd0);
        chk({tag, "_grant"},      32'(bus.grant),      32'd0);
    endtask

    initial begin
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;

        // Power-on reset
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();
        chk("wr_ready_after_rst", 32'(bus.wr_ready), 32'd1);

        // Single display read of address 5
        bus.disp_req = 1'b1; bus.disp_addr = 16'd5; rd_exp = 32'hABCDEF;
        step();
        chk("grant_disp", 32'(bus.grant), 32'd1);
        bus.disp_req = 1'b0;
        repeat (5) step();
        chk("single_read_done", 32'(rd_q.size()), 32'd0);

        // Four back-to-back writes while idle: each drains the cycle after it lands
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 16'(i); bus.wr_data = 24'(32'h10 + i);
            push_wr(i, 32'h10 + i, cyc + 2);
            step();
            chk("burst_level", 32'(bus.fifo_level), 32'd1);
            chk("burst_wr_ready", 32'(bus.wr_ready), 32'd1);
        end
        bus.wr_valid = 1'b0;
        step();
        chk("burst_level_drained", 32'(bus.fifo_level), 32'd0);
        step();
        chk("grant_idle", 32'(bus.grant), 32'd0);

        // Three writes queued behind ten cycles of display reads
        bus.disp_req = 1'b1; bus.disp_addr = 16'd5; rd_exp = 32'hABCDEF;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 16'(10 + i); bus.wr_data = 24'(32'h20 + i);
            step();
            chk("starve_fill_level", 32'(bus.fifo_level), 32'(i + 1));
        end
        bus.wr_valid = 1'b0;
        repeat (10) begin
            step();
            chk("starve_level", 32'(bus.fifo_level), 32'd3);
            chk("starve_mem_we", 32'(bus.mem_we), 32'd0);
            chk("starve_grant", 32'(bus.grant), 32'd1);
        end
        bus.disp_req = 1'b0;
        for (int i = 0; i < 3; i++) push_wr(10 + i, 32'h20 + i, cyc + 1 + i);
        repeat (3) step();
        chk("starve_drained", 32'(bus.fifo_level), 32'd0);
        repeat (3) step();

        // Out-of-range write and reads at the boundary
        bus.wr_valid = 1'b1; bus.wr_addr = 16'd38400; bus.wr_data = 24'h999999;
        step();
        chk("oor_wr_drop", 32'(bus.wr_drop), 32'd1);
        chk("oor_level", 32'(bus.fifo_level), 32'd0);
        bus.wr_valid = 1'b0;
        repeat (3) step();
        chk("oor_wr_drop_held", 32'(bus.wr_drop), 32'd1);
        bus.disp_req = 1'b1; bus.disp_addr = 16'd38400; rd_exp = 32'h0;
        step();
        bus.disp_addr = 16'd38399; rd_exp = 32'h0F0F0F;
        step();
        bus.disp_req = 1'b0;
        repeat (4) step();
        chk("oor_reads_done", 32'(rd_q.size()), 32'd0);

        // Full FIFO with a pop: level 4 -> 3 -> 4, blocked push lands one cycle later
        bus.disp_req = 1'b1; bus.disp_addr = 16'd5; rd_exp = 32'hABCDEF;
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1; bus.wr_addr = 16'(20 + i); bus.wr_data = 24'(32'h30 + i);
            step();
        end
        chk("full_level", 32'(bus.fifo_level), 32'd4);
        chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        bus.wr_addr = 16'd24; bus.wr_data = 24'h34;
        step();
        chk("full_hold_level", 32'(bus.fifo_level), 32'd4);
        bus.disp_req = 1'b0;
        push_wr(20, 32'h30, cyc + 1);
        step();
        chk("pop_level", 32'(bus.fifo_level), 32'd3);
        chk("pop_wr_ready", 32'(bus.wr_ready), 32'd1);
        bus.disp_req = 1'b1;
        step();
        chk("repush_level", 32'(bus.fifo_level), 32'd4);
        chk("repush_wr_ready", 32'(bus.wr_ready), 32'd0);
        bus.wr_valid = 1'b0; bus.disp_req = 1'b0;
        for (int i = 0; i < 4; i++) push_wr(21 + i, 32'h31 + i, cyc + 1 + i);
        repeat (4) step();
        chk("full_drained", 32'(bus.fifo_level), 32'd0);
        chk("wr_drop_sticky", 32'(bus.wr_drop), 32'd1);
        repeat (4) step();

        // Reset mid-traffic: in-flight reads and queued writes must vanish
        track = 1'b0;
        bus.disp_req = 1'b1; bus.disp_addr = 16'd5;
        bus.wr_valid = 1'b1; bus.wr_addr = 16'd30; bus.wr_data = 24'h40;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        chk_all_zero("midrst");
        reset = 1'b0; bus.disp_req = 1'b0; bus.wr_valid = 1'b0; track = 1'b1;
        step();
        chk("midrst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("midrst_level", 32'(bus.fifo_level), 32'd0);
        repeat (6) step();

        chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
